// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a dual-clock FIFO read port into a valid/ready packet stream
module fifo_rd_stream #(
   parameter int WIDTH   = 8,
   parameter int PKT_LEN = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   output logic             fifo_rd_en_o,
   input  logic [WIDTH-1:0] fifo_rd_data_i,
   input  logic             fifo_rd_empty_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_last_o
);
   localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   logic             pend_q, pend_d;
   logic [1:0]       occ_q, occ_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic [BW-1:0]    beat_q, beat_d;
   logic             pop;
   logic [2:0]       fill;

   assign m_valid_o    = ~rst_i & (occ_q != 2'd0);
   assign m_last_o     = m_valid_o & (beat_q == LAST_BEAT);
   assign m_data_o     = mem_q[rptr_q];
   assign pop          = m_valid_o & m_ready_i;
   assign fill         = {1'b0, occ_q} + {2'b0, pend_q} - {2'b0, pop};
   assign fifo_rd_en_o = ~rst_i & ~fifo_rd_empty_i & ~clear_i & (fill < 3'd2);

   // Next state: capture returned word, advance pointers and beat count; clear wins over everything
   always_comb begin
      pend_d = fifo_rd_en_o & ~fifo_rd_empty_i;
      occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
      wptr_d = wptr_q ^ pend_q;
      rptr_d = rptr_q ^ pop;
      beat_d = pop ? (m_last_o ? '0 : beat_q + BW'(1)) : beat_q;
      mem_d  = mem_q;
      if (pend_q) mem_d[wptr_q] = fifo_rd_data_i;
      if (clear_i) begin
         pend_d = 1'b0;
         occ_d  = 2'd0;
         wptr_d = 1'b0;
         rptr_d = 1'b0;
         beat_d = '0;
      end
   end

   // State registers; storage is zeroed so m_data_o reads 0 until the first capture
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q   <= 1'b0;
         occ_q    <= 2'd0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         beat_q   <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         pend_q <= pend_d;
         occ_q  <= occ_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         beat_q <= beat_d;
         mem_q  <= mem_d;
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vectors plus FIFO-model sequences for fifo_rd_stream
module tb_fifo_rd_stream;
   logic       clk_i = 0, rst_i = 0, clear_i = 0, fifo_rd_empty_i = 1, m_ready_i = 0;
   logic [7:0] fifo_rd_data_i = 0;
   logic       fifo_rd_en_o, m_valid_o, m_last_o;
   logic [7:0] m_data_o;

   always #5 clk_i = ~clk_i;

   fifo_rd_stream #(.WIDTH(8), .PKT_LEN(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
      .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_data_i(fifo_rd_data_i), .fifo_rd_empty_i(fifo_rd_empty_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o)
   );

   typedef struct {
      logic       clr;
      logic       rdy;
      logic       emp;
      logic [7:0] din;
      logic       e_rd;
      logic       e_val;
      logic [7:0] e_dat;
      logic       e_last;
   } vec_t;

   vec_t       tv [15];
   int         pass_cnt = 0, chk_cnt = 0;
   int         exp_next, beat_i, outst, pops, acc_cnt;
   bit         mon = 0;
   logic [7:0] fq [$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, got, exp, $time);
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      fifo_rd_empty_i = 0;
   endtask

   // one clock: check pops against the expected sequence, then let the FIFO model answer accepted reads
   task automatic step();
      logic acc, pp;
      @(negedge clk_i);
      acc = fifo_rd_en_o & ~fifo_rd_empty_i;
      pp  = m_valid_o & m_ready_i;
      if (mon) begin
         chk("occupancy<=2", outst <= 2, 1);
         if (pp) begin
            chk("beat data", m_data_o, exp_next & 8'hFF);
            chk("beat last", m_last_o, beat_i == 15);
            exp_next++;
            beat_i = (beat_i + 1) % 16;
         end
      end
      if (pp) pops++;
      if (acc) acc_cnt++;
      outst = outst + int'(acc) - int'(pp);
      @(posedge clk_i);
      #1;
      if (acc) fifo_rd_data_i = fq.pop_front();
      fifo_rd_empty_i = (fq.size() == 0);
   endtask

   task automatic run_pops(input int n, input int budget);
      int start, k;
      start = pops;
      k = 0;
      while ((pops - start) < n && k < budget) begin
         step();
         k++;
      end
      chk("pop count within budget", pops - start, n);
   endtask

   task automatic do_rst();
      rst_i = 1;
      clear_i = 0;
      m_ready_i = 0;
      fq.delete();
      fifo_rd_empty_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 0;
      mon = 0;
      exp_next = 0;
      beat_i = 0;
      outst = 0;
      pops = 0;
      acc_cnt = 0;
   endtask

   initial begin
      tv[0]  = '{0, 0, 1, 8'h00, 0, 0, 8'h00, 0};
      tv[1]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0};
      tv[2]  = '{0, 0, 0, 8'h11, 1, 0, 8'h00, 0};
      tv[3]  = '{0, 0, 0, 8'h22, 0, 1, 8'h11, 0};
      tv[4]  = '{0, 0, 0, 8'h99, 0, 1, 8'h11, 0};
      tv[5]  = '{0, 1, 0, 8'h99, 1, 1, 8'h11, 0};
      tv[6]  = '{0, 1, 1, 8'h33, 0, 1, 8'h22, 0};
      tv[7]  = '{0, 0, 1, 8'h00, 0, 1, 8'h33, 0};
      tv[8]  = '{0, 1, 1, 8'h00, 0, 1, 8'h33, 0};
      tv[9]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0};
      tv[10] = '{1, 0, 0, 8'h44, 0, 0, 8'h00, 0};
      tv[11] = '{0, 0, 0, 8'h55, 1, 0, 8'h00, 0};
      tv[12] = '{0, 0, 1, 8'h66, 0, 0, 8'h00, 0};
      tv[13] = '{0, 0, 1, 8'h00, 0, 1, 8'h66, 0};
      tv[14] = '{0, 1, 1, 8'h00, 0, 1, 8'h66, 0};

      // reset with a non-empty FIFO, checked before any clock edge
      #1 rst_i = 1;
      fifo_rd_empty_i = 0;
      #1;
      chk("reset rd_en", fifo_rd_en_o, 0);
      chk("reset valid", m_valid_o, 0);
      chk("reset last", m_last_o, 0);
      chk("reset data", m_data_o, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 0;

      for (int i = 0; i < 15; i++) begin
         clear_i = tv[i].clr;
         m_ready_i = tv[i].rdy;
         fifo_rd_empty_i = tv[i].emp;
         fifo_rd_data_i = tv[i].din;
         @(negedge clk_i);
         chk($sformatf("tv%0d rd_en", i), fifo_rd_en_o, tv[i].e_rd);
         chk($sformatf("tv%0d valid", i), m_valid_o, tv[i].e_val);
         if (tv[i].e_val) chk($sformatf("tv%0d data", i), m_data_o, tv[i].e_dat);
         chk($sformatf("tv%0d last", i), m_last_o, tv[i].e_last);
         @(posedge clk_i);
         #1;
      end

      // streaming 0x00..0x1F at full rate
      do_rst();
      mon = 1;
      m_ready_i = 1;
      for (int i = 0; i < 32; i++) push(i[7:0]);
      step();
      chk("stream latency 1", m_valid_o, 0);
      step();
      chk("stream latency 2", m_valid_o, 1);
      for (int i = 0; i < 32; i++) begin
         chk("stream back-to-back", m_valid_o, 1);
         step();
      end
      chk("stream count", pops, 32);
      chk("stream drained", m_valid_o, 0);

      // backpressure for 10 cycles
      do_rst();
      mon = 1;
      for (int i = 0; i < 8; i++) push(i[7:0]);
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         chk("bp rd_en", fifo_rd_en_o, 0);
         chk("bp valid", m_valid_o, 1);
         chk("bp data", m_data_o, 0);
         step();
      end
      chk("bp reads", acc_cnt, 2);
      m_ready_i = 1;
      run_pops(8, 40);
      chk("bp drained", m_valid_o, 0);

      // single word then empty
      do_rst();
      mon = 1;
      exp_next = 8'hA5;
      push(8'hA5);
      repeat (5) step();
      chk("single reads", acc_cnt, 1);
      chk("single valid", m_valid_o, 1);
      chk("single data", m_data_o, 8'hA5);
      m_ready_i = 1;
      step();
      chk("single popped", pops, 1);
      chk("single valid after", m_valid_o, 0);
      chk("single rd_en after", fifo_rd_en_o, 0);

      // flush at beat 5 with a read in flight
      do_rst();
      mon = 1;
      m_ready_i = 1;
      for (int i = 0; i < 40; i++) push(i[7:0]);
      run_pops(5, 20);
      clear_i = 1;
      m_ready_i = 0;
      #1 chk("flush rd_en", fifo_rd_en_o, 0);
      step();
      clear_i = 0;
      chk("flush valid", m_valid_o, 0);
      outst = 0;
      exp_next = fq[0];
      beat_i = 0;
      m_ready_i = 1;
      run_pops(16, 40);

      // asynchronous reset mid-packet
      do_rst();
      mon = 1;
      m_ready_i = 1;
      for (int i = 0; i < 40; i++) push(i[7:0]);
      run_pops(7, 20);
      rst_i = 1;
      #1;
      chk("async rst valid", m_valid_o, 0);
      chk("async rst rd_en", fifo_rd_en_o, 0);
      chk("async rst last", m_last_o, 0);
      mon = 0;
      step();
      step();
      rst_i = 0;
      outst = 0;
      exp_next = fq[0];
      beat_i = 0;
      mon = 1;
      run_pops(16, 40);

      // 1000 words with random ready
      do_rst();
      mon = 1;
      for (int i = 0; i < 1000; i++) push(i[7:0]);
      for (int k = 0; k < 6000 && pops < 1000; k++) begin
         m_ready_i = 1'($urandom_range(0, 1));
         step();
      end
      chk("random count", pops, 1000);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
